id_issue_stage: RTL and testbench
=================================

ID_ISSUE_STAGE -- requirements
Module: id_issue_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of operands and immediate (legal 32 or 64).
REQ-002 Parameter CNT_W, default 16, width of the stall performance counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_b  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  fetch side presents inst.
REQ-006 in_ready  output  1  stage accepts inst this cycle.
REQ-007 inst  input  32  MIPS instruction word.
REQ-008 rs_data, rt_data  input  XLEN each  register-file read data for inst[25:21], inst[20:16].
REQ-009 ex_mem_read  input  1  instruction now in EX is a load.
REQ-010 ex_dst  input  5  destination register of instruction in EX.
REQ-011 wb_we, wb_addr, wb_data  input  1/5/XLEN  writeback port used for bypass.
REQ-012 flush  input  1  discard held and incoming instruction (taken branch/jump).
REQ-013 out_ready  input  1  EX accepts the registered bundle.
REQ-014 out_valid  output  1  registered bundle valid.
REQ-015 a, b, imm  output  XLEN each  registered operands and extended immediate.
REQ-016 dst  output  5  registered destination (rd for R-type, rt for I-type/loads, 31 for jal, 0 otherwise).
REQ-017 reg_write, mem_read, mem_write, is_branch, is_jump  output  1 each  registered control.
REQ-018 halted  output  1  sticky halt indication.
REQ-019 stall_count  output  CNT_W  number of cycles a hazard bubble was inserted.

Function
REQ-020 Decode: opcode 0 R-type; 0x08-0x0F I-type ALU; 0x20/0x23 load; 0x28/0x2B store; 0x04/0x05 branch; 0x02/0x03 jump; other opcodes decode as NOP (all control 0, dst 0).
REQ-021 imm SHALL be sign-extended to XLEN except for opcodes 0x0C-0x0E, which SHALL zero-extend.
REQ-022 a SHALL be zero-extended inst[10:6] for shifts with func 0x00/0x02/0x03, else rs operand; b SHALL be imm for I-type/load/store, else rt operand.
REQ-023 Stage is a one-entry pipeline register; transfer in when in_valid && in_ready, out when out_valid && out_ready; latency exactly 1 cycle.
REQ-024 in_ready = (state==RUN) && (!out_valid || out_ready) && !hazard.
REQ-025 hazard = ex_mem_read && ex_dst!=0 && (ex_dst==rs || (rt used && ex_dst==rt)); rt used for R-type, store, branch.
REQ-026 On hazard with output slot free, stage SHALL load a bubble (out_valid 0) and increment stall_count, saturating at all-ones.
REQ-027 FSM states RUN, HALT. RUN->HALT when accepted inst is opcode 0, func 0x0C; that inst is forwarded as NOP with halted=1 the same edge. HALT is exited only by reset; in_ready 0 in HALT.
REQ-028 flush SHALL clear out_valid next edge and block acceptance that cycle; flush has priority over acceptance and hazard; flush does not exit HALT and does not count as stall.
REQ-029 out_ready low with out_valid high SHALL hold every output stable.
REQ-030 Reads of register 0 SHALL yield 0 regardless of rs_data/rt_data.

Reset
REQ-031 While rst_b low: out_valid 0, all control 0, a/b/imm 0, dst 0, halted 0, stall_count 0, state RUN.
REQ-032 Reset asserted mid-transfer SHALL discard the held instruction with no partial update.

Configuration
REQ-033 Macro ID_WB_BYPASS_EN: when defined, if wb_we && wb_addr!=0 && wb_addr matches rs/rt, wb_data SHALL replace rs_data/rt_data before operand selection.
REQ-034 Without ID_WB_BYPASS_EN, wb_* inputs SHALL be ignored; ports remain present.

Verification
REQ-035 addi $2,$0,-5 (0x2002FFFB), out_ready 1 -> next cycle out_valid 1, b=imm=0xFFFFFFFB, dst 2, reg_write 1.
REQ-036 ex_mem_read 1, ex_dst 3, inst add $4,$3,$5 -> in_ready 0, bubble one cycle, stall_count 0->1; inst accepted next cycle when ex_mem_read drops.
REQ-037 out_ready 0 for 3 cycles with valid bundle -> outputs unchanged, in_ready 0; released on out_ready 1.
REQ-038 syscall (0x0000000C) -> halted 1 next cycle, in_ready stays 0 for 10 cycles, cleared only by rst_b pulse.
REQ-039 flush with in_valid 1 and held bundle -> out_valid 0 next cycle, no acceptance, stall_count unchanged.
REQ-040 ID_WB_BYPASS_EN defined, wb_we 1, wb_addr 6, wb_data 0x1234, inst or $7,$6,$0, rs_data 0 -> a=0x1234; undefined -> a=0.

Source files
------------

// File: rtl/id_issue_stage.sv
// MIPS decode/issue stage with load-use hazard bubble; ID_WB_BYPASS_EN enables writeback-to-operand bypass.
// Latency: 1 cycle, with one registered bundle in the stage.
// Backpressure: the bundle is held while out_ready is low; in_ready drops on hazard, halt, flush or a full slot.
module id_issue_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  rs_data,
    input  logic [XLEN-1:0]  rt_data,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_dst,
    input  logic             wb_we,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [XLEN-1:0]  a,
    output logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  imm,
    output logic [4:0]       dst,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             is_branch,
    output logic             is_jump,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0] state;

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd, shamt;
    logic [5:0] func;

    assign opcode = inst[31:26];
    assign rs     = inst[25:21];
    assign rt     = inst[20:16];
    assign rd     = inst[15:11];
    assign shamt  = inst[10:6];
    assign func   = inst[5:0];

    logic is_r, is_alui, is_load, is_store, is_br, is_j, is_halt, rt_used;

    assign is_r     = (opcode == 6'h00);
    assign is_alui  = (opcode[5:3] == 3'b001);
    assign is_load  = (opcode == 6'h20) || (opcode == 6'h23);
    assign is_store = (opcode == 6'h28) || (opcode == 6'h2B);
    assign is_br    = (opcode == 6'h04) || (opcode == 6'h05);
    assign is_j     = (opcode == 6'h02) || (opcode == 6'h03);
    assign is_halt  = is_r && (func == 6'h0C);
    assign rt_used  = is_r || is_store || is_br;

    logic hazard;
    assign hazard = ex_mem_read && (ex_dst != 5'd0) &&
                    ((ex_dst == rs) || (rt_used && (ex_dst == rt)));

    logic [XLEN-1:0] rs_raw, rt_raw;
`ifdef ID_WB_BYPASS_EN
    assign rs_raw = (wb_we && (wb_addr != 5'd0) && (wb_addr == rs)) ? wb_data : rs_data;
    assign rt_raw = (wb_we && (wb_addr != 5'd0) && (wb_addr == rt)) ? wb_data : rt_data;
`else
    logic wb_unused;
    assign wb_unused = ^{wb_we, wb_addr, wb_data};
    assign rs_raw = rs_data;
    assign rt_raw = rt_data;
`endif

    logic [XLEN-1:0] rs_op, rt_op, imm_ext, a_nxt, b_nxt;
    logic            zext;

    // Register 0 is hardwired to zero, even over a bypassed value.
    assign rs_op   = (rs == 5'd0) ? '0 : rs_raw;
    assign rt_op   = (rt == 5'd0) ? '0 : rt_raw;
    assign zext    = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
    assign imm_ext = zext ? {{(XLEN-16){1'b0}}, inst[15:0]}
                          : {{(XLEN-16){inst[15]}}, inst[15:0]};
    assign a_nxt   = (is_r && ((func == 6'h00) || (func == 6'h02) || (func == 6'h03)))
                     ? {{(XLEN-5){1'b0}}, shamt} : rs_op;
    assign b_nxt   = (is_alui || is_load || is_store) ? imm_ext : rt_op;

    logic [4:0] dst_nxt;
    logic       rw_nxt, mr_nxt, mw_nxt, br_nxt, jp_nxt;

    always_comb begin
        dst_nxt = 5'd0;
        rw_nxt  = 1'b0;
        mr_nxt  = 1'b0;
        mw_nxt  = 1'b0;
        br_nxt  = 1'b0;
        jp_nxt  = 1'b0;
        if (is_r && !is_halt) begin
            rw_nxt  = 1'b1;
            dst_nxt = rd;
        end else if (is_alui) begin
            rw_nxt  = 1'b1;
            dst_nxt = rt;
        end else if (is_load) begin
            rw_nxt  = 1'b1;
            mr_nxt  = 1'b1;
            dst_nxt = rt;
        end else if (is_store) begin
            mw_nxt  = 1'b1;
        end else if (is_br) begin
            br_nxt  = 1'b1;
        end else if (is_j) begin
            jp_nxt  = 1'b1;
            if (opcode == 6'h03) begin
                rw_nxt  = 1'b1;
                dst_nxt = 5'd31;
            end
        end
    end

    logic slot_free, run, accept, stall_evt;

    assign run       = (state == ST_RUN);
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = run && slot_free && !hazard && !flush;
    assign accept    = in_valid && in_ready;
    assign stall_evt = run && in_valid && hazard && slot_free && !flush;
    assign halted    = (state == ST_HALT);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= ST_RUN;
            out_valid   <= 1'b0;
            a           <= '0;
            b           <= '0;
            imm         <= '0;
            dst         <= 5'd0;
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            is_branch   <= 1'b0;
            is_jump     <= 1'b0;
            stall_count <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                a         <= a_nxt;
                b         <= b_nxt;
                imm       <= imm_ext;
                dst       <= dst_nxt;
                reg_write <= rw_nxt;
                mem_read  <= mr_nxt;
                mem_write <= mw_nxt;
                is_branch <= br_nxt;
                is_jump   <= jp_nxt;
            end else if (slot_free) begin
                out_valid <= 1'b0;
            end
            // Halt is sticky until reset; the halting word itself leaves as a NOP.
            if (accept && is_halt) begin
                state <= ST_HALT;
            end
            if (stall_evt && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: per-cycle comparison against a behavioural model plus literal checks.
module tb_id_issue_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_b = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      inst = '0;
    logic [XLEN-1:0]  rs_data = '0;
    logic [XLEN-1:0]  rt_data = '0;
    logic             ex_mem_read = 1'b0;
    logic [4:0]       ex_dst = '0;
    logic             wb_we = 1'b0;
    logic [4:0]       wb_addr = '0;
    logic [XLEN-1:0]  wb_data = '0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [XLEN-1:0]  a, b, imm;
    logic [4:0]       dst;
    logic             reg_write, mem_read, mem_write, is_branch, is_jump;
    logic             halted;
    logic [CNT_W-1:0] stall_count;

    id_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .rs_data(rs_data), .rt_data(rt_data), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .out_ready(out_ready), .out_valid(out_valid), .a(a), .b(b), .imm(imm), .dst(dst),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .is_branch(is_branch), .is_jump(is_jump), .halted(halted), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic [4:0]  ctrl;   // reg_write, mem_read, mem_write, is_branch, is_jump
    } bundle_t;

    function automatic bundle_t spec_decode(input logic [31:0] w, input logic [31:0] rsd,
                                            input logic [31:0] rtd);
        bundle_t r;
        int op, fn, rsn, rtn;
        logic [31:0] rsv, rtv;
        op  = int'(w[31:26]);
        fn  = int'(w[5:0]);
        rsn = int'(w[25:21]);
        rtn = int'(w[20:16]);
        rsv = rsd;
        rtv = rtd;
`ifdef ID_WB_BYPASS_EN
        if (wb_we && wb_addr != 0) begin
            if (int'(wb_addr) == rsn) rsv = wb_data;
            if (int'(wb_addr) == rtn) rtv = wb_data;
        end
`endif
        if (rsn == 0) rsv = 0;
        if (rtn == 0) rtv = 0;
        r.imm = (op >= 12 && op <= 14) ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
        r.a = (op == 0 && (fn == 0 || fn == 2 || fn == 3)) ? 32'(w[10:6]) : rsv;
        r.b = ((op >= 8 && op <= 15) || op == 32 || op == 35 || op == 40 || op == 43) ? r.imm : rtv;
        r.dst  = 5'd0;
        r.ctrl = 5'b00000;
        if (op == 0 && fn != 12)            begin r.ctrl = 5'b10000; r.dst = w[15:11]; end
        else if (op >= 8 && op <= 15)       begin r.ctrl = 5'b10000; r.dst = w[20:16]; end
        else if (op == 32 || op == 35)      begin r.ctrl = 5'b11000; r.dst = w[20:16]; end
        else if (op == 40 || op == 43)      r.ctrl = 5'b00100;
        else if (op == 4 || op == 5)        r.ctrl = 5'b00010;
        else if (op == 2)                   r.ctrl = 5'b00001;
        else if (op == 3)                   begin r.ctrl = 5'b10001; r.dst = 5'd31; end
        return r;
    endfunction

    bit          m_vld = 1'b0;
    bit          m_halt = 1'b0;
    int          m_stall = 0;
    bundle_t     m_bun = '0;

    function automatic bit m_hazard();
        int op, rsn, rtn;
        bit rt_used;
        op  = int'(inst[31:26]);
        rsn = int'(inst[25:21]);
        rtn = int'(inst[20:16]);
        rt_used = (op == 0) || op == 40 || op == 43 || op == 4 || op == 5;
        return ex_mem_read && ex_dst != 0 &&
               (int'(ex_dst) == rsn || (rt_used && int'(ex_dst) == rtn));
    endfunction

    function automatic bit m_in_ready();
        return !m_halt && (!m_vld || out_ready) && !m_hazard() && !flush;
    endfunction

    always @(posedge clk or negedge rst_b) begin
        bit free, acc;
        if (!rst_b) begin
            m_vld = 0; m_halt = 0; m_stall = 0;
        end else begin
            free = !m_vld || out_ready;
            acc  = in_valid && m_in_ready();
            if (flush) m_vld = 0;
            else if (acc) begin
                m_vld = 1;
                m_bun = spec_decode(inst, rs_data, rt_data);
                if (inst[31:26] == 6'd0 && inst[5:0] == 6'h0C) m_halt = 1;
            end else if (free) begin
                m_vld = 0;
                if (!m_halt && in_valid && m_hazard() && m_stall < (1 << CNT_W) - 1) m_stall++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_b && chk_on) begin
            chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
            chk("out_valid", 64'(out_valid), 64'(m_vld));
            chk("halted", 64'(halted), 64'(m_halt));
            chk("stall_count", 64'(stall_count), 64'(m_stall));
            if (m_vld) begin
                chk("a", 64'(a), 64'(m_bun.a));
                chk("b", 64'(b), 64'(m_bun.b));
                chk("imm", 64'(imm), 64'(m_bun.imm));
                chk("dst", 64'(dst), 64'(m_bun.dst));
                chk("ctrl", 64'({reg_write, mem_read, mem_write, is_branch, is_jump}), 64'(m_bun.ctrl));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] w, input logic [31:0] rsd, input logic [31:0] rtd);
        in_valid = 1'b1;
        inst     = w;
        rs_data  = rsd;
        rt_data  = rtd;
        tick();
        in_valid = 1'b0;
    endtask

    localparam logic [31:0] ADDI   = 32'h2002FFFB;   // addi $2,$0,-5
    localparam logic [31:0] ADD    = 32'h00652020;   // add $4,$3,$5
    localparam logic [31:0] LW     = 32'h8C270008;   // lw $7,8($1)
    localparam logic [31:0] ORI    = 32'h34C58001;   // ori $5,$6,0x8001
    localparam logic [31:0] OR0    = 32'h00C03825;   // or $7,$6,$0
    localparam logic [31:0] SYSC   = 32'h0000000C;

    logic [31:0] vecs [8] = '{32'h00031100, ORI, LW, 32'hAC27FFFC, 32'h10220003,
                              32'h0C000010, 32'h08000010, 32'hFC000000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst a", 64'(a), 64'd0);
        chk("rst b", 64'(b), 64'd0);
        chk("rst imm", 64'(imm), 64'd0);
        chk("rst dst", 64'(dst), 64'd0);
        chk("rst ctrl", 64'({reg_write, mem_read, mem_write, is_branch, is_jump}), 64'd0);
        chk("rst halted", 64'(halted), 64'd0);
        chk("rst stall_count", 64'(stall_count), 64'd0);
        rst_b = 1'b1;
        chk_on = 1'b1;
        out_ready = 1'b1;

        // addi with negative immediate
        issue(ADDI, 32'hDEAD0000, 32'h0BADBEEF);
        chk("addi out_valid", 64'(out_valid), 64'd1);
        chk("addi b", 64'(b), 64'hFFFFFFFB);
        chk("addi imm", 64'(imm), 64'hFFFFFFFB);
        chk("addi dst", 64'(dst), 64'd2);
        chk("addi reg_write", 64'(reg_write), 64'd1);

        // decode table: sll, ori, lw, sw, beq, jal, j, unknown
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i], $urandom, $urandom);
            if (i == 0) chk("sll a shamt", 64'(a), 64'd4);
            if (i == 1) chk("ori imm zext", 64'(imm), 64'h00008001);
            if (i == 5) chk("jal dst", 64'(dst), 64'd31);
            if (i == 7) chk("nop ctrl", 64'({reg_write, mem_read, mem_write, is_branch, is_jump, dst}), 64'd0);
        end
        issue(OR0, 32'h11112222, 32'h5555AAAA);
        chk("rt zero reg", 64'(b), 64'd0);

        // load-use hazard
        ex_mem_read = 1'b1;
        ex_dst = 5'd3;
        in_valid = 1'b1;
        inst = ADD;
        #1;
        chk("hazard in_ready", 64'(in_ready), 64'd0);
        chk("hazard stall before", 64'(stall_count), 64'd0);
        tick();
        chk("hazard stall after", 64'(stall_count), 64'd1);
        chk("hazard bubble", 64'(out_valid), 64'd0);
        ex_mem_read = 1'b0;
        #1;
        chk("hazard release rdy", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("hazard accepted", 64'(out_valid), 64'd1);
        chk("hazard dst", 64'(dst), 64'd4);

        // backpressure holds the lw bundle
        issue(LW, 32'h100, 32'h200);
        out_ready = 1'b0;
        in_valid = 1'b1;
        inst = ADDI;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp in_ready", 64'(in_ready), 64'd0);
            chk("bp out_valid", 64'(out_valid), 64'd1);
            chk("bp dst", 64'(dst), 64'd7);
            chk("bp imm", 64'(imm), 64'd8);
            chk("bp mem_read", 64'(mem_read), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp release dst", 64'(dst), 64'd2);

        // flush with held bundle and incoming word
        issue(ADD, 32'h7, 32'h9);
        out_ready = 1'b0;
        in_valid = 1'b1;
        inst = ORI;
        flush = 1'b1;
        #1;
        chk("flush in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush out_valid", 64'(out_valid), 64'd0);
        chk("flush stall", 64'(stall_count), 64'd1);
        out_ready = 1'b1;

        // stall counter saturation
        ex_mem_read = 1'b1;
        ex_dst = 5'd3;
        in_valid = 1'b1;
        inst = ADD;
        repeat (8) tick();
        chk("stall saturate", 64'(stall_count), 64'd7);
        ex_mem_read = 1'b0;
        in_valid = 1'b0;
        tick();

        // writeback bypass
        wb_we = 1'b1;
        wb_addr = 5'd6;
        wb_data = 32'h1234;
        issue(OR0, 32'h0, 32'h5555);
`ifdef ID_WB_BYPASS_EN
        chk("bypass a", 64'(a), 64'h1234);
`else
        chk("bypass a", 64'(a), 64'h0);
`endif
        wb_we = 1'b0;

        // reset in the middle of a held transfer
        issue(ADDI, 32'h0, 32'h0);
        out_ready = 1'b0;
        tick();
        rst_b = 1'b0;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst dst", 64'(dst), 64'd0);
        chk("midrst stall", 64'(stall_count), 64'd0);
        tick();
        rst_b = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post rst out_valid", 64'(out_valid), 64'd0);

        // syscall halts
        issue(SYSC, 32'hABCD, 32'h1234);
        chk("halt halted", 64'(halted), 64'd1);
        chk("halt out_valid", 64'(out_valid), 64'd1);
        chk("halt nop", 64'({reg_write, mem_read, mem_write, is_branch, is_jump, dst}), 64'd0);
        in_valid = 1'b1;
        inst = ADDI;
        for (int i = 0; i < 10; i++) begin
            chk("halt in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("halt after flush", 64'(halted), 64'd1);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        #1;
        chk("halt cleared", 64'(halted), 64'd0);
        chk("run in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("run accept", 64'(out_valid), 64'd1);
        chk("run dst", 64'(dst), 64'd2);
        tick();
        tick();

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
